// File: rtl/free_list_pkg.sv
// Shared rename/backend sizing for the physical-register free list.
package free_list_pkg;

   localparam int DEF_ID_WIDTH     = 2;   // rename lanes
   localparam int DEF_COMMIT_WIDTH = 2;   // commit lanes
   localparam int DEF_PRF_IDX      = 6;   // physical register index width
   localparam int DEF_NUM_ARF      = 32;  // architectural registers

   // Physical registers not holding an architectural mapping at reset.
   localparam int DEF_FL_DEPTH = (2 ** DEF_PRF_IDX) - DEF_NUM_ARF;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free PRF indices with a
// speculative head (rename allocations), a retire head (committed
// allocations) and a tail (stale registers returned at commit). A flush
// rewinds the speculative head to the retire head.
module free_list
   import free_list_pkg::*;
#(
   parameter int ID_WIDTH     = DEF_ID_WIDTH,
   parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
   parameter int PRF_IDX      = DEF_PRF_IDX,
   parameter int NUM_ARF      = DEF_NUM_ARF,
   parameter int FL_DEPTH     = (2 ** PRF_IDX) - NUM_ARF
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ID_WIDTH-1:0]                   from_id_valid,
   output logic                                  from_id_ready,
   output logic [ID_WIDTH-1:0][PRF_IDX-1:0]      from_id_free_idx,
   input  logic [COMMIT_WIDTH-1:0]               from_rob_valid,
   input  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0]  from_rob_stale_idx,
   input  logic                                  flush
);

   localparam int AW = $clog2(FL_DEPTH);
   localparam int PW = AW + 1;  // extra MSB is the wrap bit

   logic [PRF_IDX-1:0] mem [FL_DEPTH];
   logic [PW-1:0]      spec_head;
   logic [PW-1:0]      retire_head;
   logic [PW-1:0]      tail;

   logic [PW-1:0]      count;
   logic [PW-1:0]      id_off [ID_WIDTH];
   logic [PW-1:0]      id_acc;
   logic [PW-1:0]      id_sum;
   logic [PW-1:0]      pop_sum;
   logic [PW-1:0]      cm_off [COMMIT_WIDTH];
   logic [PW-1:0]      cm_acc;
   logic [PW-1:0]      cm_sum;
   logic [PW-1:0]      retire_next;
   logic [AW-1:0]      wr_ptr [COMMIT_WIDTH];

   // Free entries; modular subtraction over the wrap-bit pointers.
   assign count = tail - spec_head;

   // Depends only on registered count and flush, never on valid, so rename
   // can raise valid after seeing ready without a combinational loop.
   assign from_id_ready = !flush && (count >= PW'(ID_WIDTH));

   // Rename lane offsets: a lane only consumes a slot if it requests one.
   always_comb begin
      id_acc = '0;
      for (int i = 0; i < ID_WIDTH; i++) begin
         id_off[i] = id_acc;
         id_acc    = id_acc + PW'(from_id_valid[i]);
      end
      id_sum = id_acc;
   end

   // Commit lane offsets: stale registers land in lane order at the tail.
   always_comb begin
      cm_acc = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         cm_off[j] = cm_acc;
         wr_ptr[j] = AW'(tail + cm_acc);
         cm_acc    = cm_acc + PW'(from_rob_valid[j]);
      end
      cm_sum = cm_acc;
   end

   assign pop_sum     = from_id_ready ? id_sum : '0;
   assign retire_next = retire_head + cm_sum;

   // Offered indices are read straight from storage; no push bypass.
   for (genvar i = 0; i < ID_WIDTH; i++) begin : g_lane
      logic [AW-1:0] rd_ptr;
      assign rd_ptr              = AW'(spec_head + id_off[i]);
      assign from_id_free_idx[i] = mem[rd_ptr];
   end

   // Pointer and storage update: reset refills the list, commits push stale
   // registers, and flush rewinds the speculative head past same-cycle commits.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < FL_DEPTH; k++) begin
            mem[k] <= PRF_IDX'(NUM_ARF + k);
         end
         spec_head   <= '0;
         retire_head <= '0;
         tail        <= PW'(FL_DEPTH);
      end else begin
         for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (from_rob_valid[j]) begin
               mem[wr_ptr[j]] <= from_rob_stale_idx[j];
            end
         end
         tail        <= tail + cm_sum;
         retire_head <= retire_next;
         if (flush) begin
            spec_head <= retire_next;
         end else begin
            spec_head <= spec_head + pop_sum;
         end
      end
   end

   // Bookkeeping invariants checked in simulation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= PW'(FL_DEPTH));
         assert ((tail - retire_head) == PW'(FL_DEPTH));
         assert ((count - pop_sum + cm_sum) <= PW'(FL_DEPTH));
         for (int j = 0; j < COMMIT_WIDTH; j++) begin
            assert (!from_rob_valid[j] || (from_rob_stale_idx[j] != '0));
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Table-driven bench for free_list: each row is one cycle of inputs plus the
// hand-derived ready/free_idx expected in that cycle. Expected records go to
// a scoreboard queue when a row is driven and are popped when sampled.
module tb_free_list;
   import free_list_pkg::*;

   localparam int IW = DEF_ID_WIDTH;
   localparam int CW = DEF_COMMIT_WIDTH;
   localparam int PI = DEF_PRF_IDX;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [IW-1:0]           valid = '0;
   logic                    ready;
   logic [IW-1:0][PI-1:0]   free_idx;
   logic [CW-1:0]           rob_valid = '0;
   logic [CW-1:0][PI-1:0]   stale_idx = '0;
   logic                    flush = 1'b0;

   free_list dut (
      .clk               (clk),
      .rst               (rst),
      .from_id_valid     (valid),
      .from_id_ready     (ready),
      .from_id_free_idx  (free_idx),
      .from_rob_valid    (rob_valid),
      .from_rob_stale_idx(stale_idx),
      .flush             (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          flush;
      logic [1:0]    v;
      logic [1:0]    cv;
      logic [PI-1:0] s0;
      logic [PI-1:0] s1;
      logic          chk;
      logic          rdy;
      logic [PI-1:0] f0;
      logic [PI-1:0] f1;
   } vec_t;

   typedef struct {
      int row;
      int rdy;
      int f0;
      int f1;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic add(input int r, input int fl, input int v, input int cv,
                      input int s0, input int s1, input int c, input int rdy,
                      input int f0, input int f1);
      vec_t e;
      e.rst = 1'(r);   e.flush = 1'(fl);
      e.v   = 2'(v);   e.cv    = 2'(cv);
      e.s0  = PI'(s0); e.s1    = PI'(s1);
      e.chk = 1'(c);   e.rdy   = 1'(rdy);
      e.f0  = PI'(f0); e.f1    = PI'(f1);
      tbl.push_back(e);
   endtask

   task automatic do_reset();
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check(input string name, input int row, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s row %0d: got %0d, required %0d", name, row, act, req);
      end
   endtask

   initial begin
      exp_t e;

      // Reset state and lane skip.
      do_reset();
      add(0, 0, 0, 0, 0, 0, 1, 1, 32, 32);
      add(0, 0, 2, 0, 0, 0, 1, 1, 32, 32);
      add(0, 0, 0, 0, 0, 0, 1, 1, 33, 33);
      add(0, 0, 1, 0, 0, 0, 1, 1, 33, 34);
      add(0, 0, 3, 0, 0, 0, 1, 1, 34, 35);
      add(0, 0, 0, 0, 0, 0, 1, 1, 36, 36);

      // Mid-operation reset, then full drain; empty list holds its pointers.
      do_reset();
      for (int c = 0; c < 16; c++) add(0, 0, 3, 0, 0, 0, 1, 1, 32 + 2*c, 33 + 2*c);
      add(0, 0, 3, 0, 0, 0, 1, 0, 32, 33);
      add(0, 0, 3, 0, 0, 0, 1, 0, 32, 33);

      // Drain 31, commit {5,7} at count 1 (no pop, no bypass), wrap the
      // tail, then a near-empty commit of 1 that lifts count to 2.
      do_reset();
      for (int c = 0; c < 15; c++) add(0, 0, 3, 0, 0, 0, 1, 1, 32 + 2*c, 33 + 2*c);
      add(0, 0, 1, 0, 0, 0, 1, 1, 62, 63);
      add(0, 0, 1, 3, 5, 7, 1, 0, 63, 32);
      add(0, 0, 3, 0, 0, 0, 1, 1, 63, 5);
      add(0, 0, 1, 1, 11, 0, 1, 0, 7, 34);
      add(0, 0, 3, 0, 0, 0, 1, 1, 7, 11);
      add(0, 0, 0, 0, 0, 0, 1, 0, 35, 35);

      // Flush: allocate 6, commit {1,2}, flush with valid=11; then a flush
      // with a same-cycle commit so the rewind must include that commit.
      do_reset();
      add(0, 0, 3, 0, 0, 0, 1, 1, 32, 33);
      add(0, 0, 3, 0, 0, 0, 1, 1, 34, 35);
      add(0, 0, 3, 0, 0, 0, 1, 1, 36, 37);
      add(0, 0, 0, 3, 1, 2, 1, 1, 38, 38);
      add(0, 1, 3, 0, 0, 0, 1, 0, 38, 39);
      add(0, 0, 0, 0, 0, 0, 1, 1, 34, 34);
      add(0, 0, 3, 0, 0, 0, 1, 1, 34, 35);
      add(0, 1, 3, 1, 9, 0, 1, 0, 36, 37);
      add(0, 0, 1, 0, 0, 0, 1, 1, 35, 36);

      foreach (tbl[n]) begin
         @(posedge clk);
         #1;
         rst          = tbl[n].rst;
         flush        = tbl[n].flush;
         valid        = tbl[n].v;
         rob_valid    = tbl[n].cv;
         stale_idx[0] = tbl[n].s0;
         stale_idx[1] = tbl[n].s1;
         if (tbl[n].chk) begin
            e.row = n;
            e.rdy = int'(tbl[n].rdy);
            e.f0  = int'(tbl[n].f0);
            e.f1  = int'(tbl[n].f1);
            sb.push_back(e);
         end
         @(negedge clk);
         if (tbl[n].chk && sb.size() > 0) begin
            e = sb.pop_front();
            check("ready",       e.row, int'(ready),       e.rdy);
            check("free_idx[0]", e.row, int'(free_idx[0]), e.f0);
            check("free_idx[1]", e.row, int'(free_idx[1]), e.f1);
         end
      end

      check("scoreboard_left", -1, sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
